eth_10g_mchnl_tx_arb: RTL and testbench
=======================================

Name: eth_10g_mchnl_tx_arb

Overview:
- Multi-channel TX front end for the 10G MAC user side.
- Merges P_CHANNEL_NUM 64-bit AXI-Stream user sources into one MAC TX stream using per-frame round-robin arbitration.
- Enforces frame length at this interface: short frames are zero-padded up to P_MIN_LENGTH; long frames are truncated at P_MAX_LENGTH and flagged in tuser.
- Runs in the MAC tx_clk domain, between the user logic and the tx0_axis_* port of the 10G control top.

Parameters:
- P_CHANNEL_NUM, 4: number of user source channels, 1..8.
- P_MIN_LENGTH, 8'd64: minimum emitted frame length in bytes; must be a multiple of 8.
- P_MAX_LENGTH, 15'd9600: maximum emitted frame length in bytes; must be ≥ P_MIN_LENGTH.

Ports:
- i_clk  in  1  MAC tx clock.
- i_rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  P_CHANNEL_NUM  per-channel valid.
- s_axis_tdata  in  64*P_CHANNEL_NUM  channel c occupies bits [64c+63:64c].
- s_axis_tkeep  in  8*P_CHANNEL_NUM  contiguous from lane 0; partial keep only on the last beat.
- s_axis_tlast  in  P_CHANNEL_NUM  end of frame.
- s_axis_tuser  in  P_CHANNEL_NUM  source error flag, forwarded.
- s_axis_tready  out  P_CHANNEL_NUM  per-channel ready.
- m_axis_tvalid / m_axis_tdata[63:0] / m_axis_tkeep[7:0] / m_axis_tlast / m_axis_tuser  out  to the MAC.
- m_axis_tready  in  1  MAC ready.
- o_grant_chnl  out  clog2(P_CHANNEL_NUM) (min 1)  currently granted channel.
- o_busy  out  1  high when state ≠ IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous and active-high.
- Reset values: state IDLE; RR pointer 0; byte count 0; all s_axis_tready 0; m_axis_tvalid 0; o_busy 0; o_grant_chnl 0.
- The m_axis outputs are combinational from the state and the granted channel, so there is zero added latency in DATA.
- IDLE:
  - Pick the first channel with tvalid, scanning from the RR pointer upward with wrap.
  - Latch it into the grant register and go to DATA on the next cycle.
  - This costs one cycle per frame.
  - If no channel is valid, stay in IDLE.
- DATA:
  - m_axis = granted channel; s_axis_tready[g] = m_axis_tready; all other readies are 0.
  - byte_cnt (16 bits) adds popcount(tkeep) on each accepted beat. nb = byte_cnt + popcount.
  - Truncation: a beat with nb ≥ P_MAX_LENGTH and no tlast is emitted with:
    - tkeep trimmed so the frame total is exactly P_MAX_LENGTH;
    - tlast = 1; tuser = 1;
    - next state DRAIN.
  - A tlast beat with nb > P_MAX_LENGTH gets the same trimming and tuser = 1, and goes to IDLE.
  - A tlast beat with nb == P_MAX_LENGTH passes through normally.
  - Short frame: a tlast beat with nb < P_MIN_LENGTH is emitted with:
    - tkeep = 8'hFF, unused lanes zeroed;
    - tlast = 0; tuser = source tuser;
    - byte_cnt rounded up to the next multiple of 8;
    - next state PAD.
  - If widening that beat to 8 bytes reaches P_MIN_LENGTH, the beat is instead emitted as the final beat: tkeep = 8'hFF, tlast = 1, zero-filled lanes, next state IDLE.
  - Normal tlast: go to IDLE and set the RR pointer to g+1 (wrapping).
- PAD:
  - Emit zero-data, tkeep = 8'hFF beats while m_axis_tready is high; each accepted beat adds 8 to byte_cnt.
  - The beat that reaches P_MIN_LENGTH carries tlast = 1 and the latched source tuser, and returns to IDLE.
  - All s_axis_tready are 0 in PAD.
- DRAIN:
  - s_axis_tready[g] = 1; m_axis_tvalid = 0.
  - Discard beats until the granted channel's tlast is accepted, then go to IDLE and advance the RR pointer.
- A granted channel whose tvalid drops mid-frame simply stalls; there is no timeout.
- On entry to IDLE, byte_cnt is cleared.
- Reset asserted mid-frame returns to the reset state immediately. The partial frame is not completed on the MAC side; the MAC is reset alongside.

Optional Feature:
- Macro: ETH_TX_ARB_STAT_EN.
- Defined: adds the following outputs, all cleared by i_rst and saturating at all-ones:
  - o_frm_cnt[32*P_CHANNEL_NUM-1:0]: frames completed per channel, incremented on each emitted tlast;
  - o_trunc_cnt[31:0]: count of truncation events;
  - o_pad_cnt[31:0]: count of frames entering PAD or zero-fill completion.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package eth_10g_pkg holds:
  - the 64-bit data width and 8-bit keep width constants;
  - the state encoding (IDLE, DATA, PAD, DRAIN);
  - functions f_popcnt8(keep) and f_keep_from_bytes(n), where 0 maps to 8'hFF.
- Sub-module eth_10g_rr_arbiter: combinational round-robin pick from a request vector and a pointer, with outputs grant index and any_req. The FSM, counters and muxing stay in the top.

Test Plan:
- Single channel, 128-byte frame (16 full beats), m_axis_tready = 1 → 16 identical beats out, tlast on beat 16, tuser = 0, one IDLE bubble cycle before the next frame.
- Channels 0, 1 and 2 each continuously offer 64-byte frames → output order is 0, 1, 2, 0, 1, 2…, and o_grant_chnl follows the same sequence.
- 20-byte frame (beats of 8, 8, then keep 8'h0F) → 8 output beats totalling 64 bytes: beat 3 has keep FF with lanes 4–7 zero, beats 4–8 are zero data, tlast only on beat 8.
- 9608-byte frame with P_MAX_LENGTH = 9600 → output of 1200 full beats, tlast and tuser set on beat 1200; source beat 1201 is drained; the next frame starts clean.
- MAC applies random m_axis_tready backpressure during DATA and PAD → no beat is lost or duplicated, and tdata/tkeep/tlast are held stable while tvalid is high and tready is low.
- Assert i_rst during PAD, deassert, then send a 64-byte frame on channel 1 → all outputs are 0 while in reset; afterwards the frame on channel 1 emerges intact with grant = 1.

Source files
------------

// File: rtl/eth_10g_pkg.sv
// Shared constants, FSM encoding and keep helpers for the 10G MAC TX user-side logic.
package eth_10g_pkg;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned KeepWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StData  = 2'd1,
    StPad   = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  // Number of valid byte lanes in a keep vector.
  function automatic logic [3:0] f_popcnt8(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, keep[i]};
    end
    return cnt;
  endfunction

  // Contiguous keep for n bytes; 0 (and 8) mean a full beat.
  function automatic logic [7:0] f_keep_from_bytes(input logic [3:0] n);
    logic [7:0] keep;
    if (n == 4'd0 || n >= 4'd8) begin
      keep = 8'hFF;
    end else begin
      keep = (8'h01 << n) - 8'h01;
    end
    return keep;
  endfunction

endpackage

// File: rtl/eth_10g_rr_arbiter.sv
// Combinational round-robin pick: lowest request index at or above the pointer, with wrap.
module eth_10g_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   grant_o,
  output logic              any_req_o
);

  int unsigned off;
  int unsigned best;

  // Choose the requester with the smallest wrapped distance from the pointer.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    off       = 0;
    best      = NumReq;
    for (int unsigned j = 0; j < NumReq; j++) begin
      off = (j >= 32'(ptr_i)) ? (j - 32'(ptr_i)) : (j + NumReq - 32'(ptr_i));
      if (req_i[j] && (off < best)) begin
        best      = off;
        grant_o   = IdxW'(j);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_10g_mchnl_tx_arb.sv
// Multi-channel TX arbiter: per-frame round-robin merge of 64-bit AXI-Stream sources into the
// MAC TX stream, padding short frames to P_MIN_LENGTH and truncating at P_MAX_LENGTH.
// Optional per-channel/truncation/pad statistics counters: define ETH_TX_ARB_STAT_EN.
module eth_10g_mchnl_tx_arb
  import eth_10g_pkg::*;
#(
  parameter int unsigned P_CHANNEL_NUM = 4,
  parameter logic [7:0]  P_MIN_LENGTH  = 8'd64,
  parameter logic [14:0] P_MAX_LENGTH  = 15'd9600,
  localparam int unsigned GrantW = (P_CHANNEL_NUM > 1) ? $clog2(P_CHANNEL_NUM) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [P_CHANNEL_NUM-1:0]         s_axis_tvalid,
  input  logic [64*P_CHANNEL_NUM-1:0]      s_axis_tdata,
  input  logic [8*P_CHANNEL_NUM-1:0]       s_axis_tkeep,
  input  logic [P_CHANNEL_NUM-1:0]         s_axis_tlast,
  input  logic [P_CHANNEL_NUM-1:0]         s_axis_tuser,
  output logic [P_CHANNEL_NUM-1:0]         s_axis_tready,
  output logic                             m_axis_tvalid,
  output logic [63:0]                      m_axis_tdata,
  output logic [7:0]                       m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser,
  input  logic                             m_axis_tready,
  output logic [GrantW-1:0]                o_grant_chnl,
`ifdef ETH_TX_ARB_STAT_EN
  output logic [32*P_CHANNEL_NUM-1:0]      o_frm_cnt,
  output logic [31:0]                      o_trunc_cnt,
  output logic [31:0]                      o_pad_cnt,
`endif
  output logic                             o_busy
);

  arb_state_e          state_q;
  logic [GrantW-1:0]   grant_q, rr_ptr_q, rr_next, arb_grant;
  logic [15:0]         byte_cnt_q;
  logic                pad_user_q;
  logic                any_req;

  logic                in_valid, in_last, in_user, beat_acc;
  logic [63:0]         in_data, lane_mask;
  logic [7:0]          in_keep, trim_keep;
  logic [15:0]         nb, widened, trim_bytes, max_len, min_len;
  logic                is_trunc, is_short, short_done, pad_last;

  eth_10g_rr_arbiter #(
    .NumReq (P_CHANNEL_NUM),
    .IdxW   (GrantW)
  ) u_rr_arbiter (
    .req_i     (s_axis_tvalid),
    .ptr_i     (rr_ptr_q),
    .grant_o   (arb_grant),
    .any_req_o (any_req)
  );

  // Classify the granted channel's current beat against the length limits.
  always_comb begin
    in_valid   = s_axis_tvalid[grant_q];
    in_data    = s_axis_tdata[DataWidth*grant_q +: DataWidth];
    in_keep    = s_axis_tkeep[KeepWidth*grant_q +: KeepWidth];
    in_last    = s_axis_tlast[grant_q];
    in_user    = s_axis_tuser[grant_q];
    beat_acc   = in_valid & m_axis_tready;
    max_len    = {1'b0, P_MAX_LENGTH};
    min_len    = {8'd0, P_MIN_LENGTH};
    nb         = byte_cnt_q + {12'd0, f_popcnt8(in_keep)};
    widened    = (nb + 16'd7) & 16'hFFF8;
    // Only reached when the limit falls inside this beat, so the difference is 1..8.
    trim_bytes = max_len - byte_cnt_q;
    trim_keep  = f_keep_from_bytes(trim_bytes[3:0]);
    is_trunc   = in_last ? (nb > max_len) : (nb >= max_len);
    is_short   = in_last & ~is_trunc & (nb < min_len);
    short_done = widened >= min_len;
    pad_last   = (byte_cnt_q + 16'd8) >= min_len;
    rr_next    = (grant_q == GrantW'(P_CHANNEL_NUM - 1)) ? '0 : grant_q + GrantW'(1);
    lane_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{in_keep[i]}};
    end
  end

  // Output mux: zero-latency pass-through of the granted channel, padding, or drain.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state_q)
      StData: begin
        s_axis_tready[grant_q] = m_axis_tready;
        m_axis_tvalid = in_valid;
        m_axis_tdata  = in_data;
        m_axis_tkeep  = in_keep;
        m_axis_tlast  = in_last;
        m_axis_tuser  = in_user;
        if (is_trunc) begin
          m_axis_tkeep = trim_keep;
          m_axis_tlast = 1'b1;
          m_axis_tuser = 1'b1;
        end else if (is_short) begin
          m_axis_tdata = in_data & lane_mask;
          m_axis_tkeep = 8'hFF;
          m_axis_tlast = short_done;
        end
      end
      StPad: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 8'hFF;
        m_axis_tlast  = pad_last;
        m_axis_tuser  = pad_last & pad_user_q;
      end
      StDrain: s_axis_tready[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign o_grant_chnl = grant_q;
  assign o_busy       = (state_q != StIdle);

  // Frame-level FSM with grant, round-robin pointer and byte counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      pad_user_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          byte_cnt_q <= '0;
          if (any_req) begin
            grant_q <= arb_grant;
            state_q <= StData;
          end
        end
        StData: begin
          if (beat_acc) begin
            if (is_trunc && !in_last) begin
              state_q <= StDrain;
            end else if (is_short && !short_done) begin
              byte_cnt_q <= widened;
              pad_user_q <= in_user;
              state_q    <= StPad;
            end else if (in_last) begin
              byte_cnt_q <= '0;
              rr_ptr_q   <= rr_next;
              state_q    <= StIdle;
            end else begin
              byte_cnt_q <= nb;
            end
          end
        end
        StPad: begin
          if (m_axis_tready) begin
            byte_cnt_q <= byte_cnt_q + 16'd8;
            if (pad_last) begin
              byte_cnt_q <= '0;
              rr_ptr_q   <= rr_next;
              state_q    <= StIdle;
            end
          end
        end
        StDrain: begin
          if (in_valid && in_last) begin
            byte_cnt_q <= '0;
            rr_ptr_q   <= rr_next;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ETH_TX_ARB_STAT_EN
  logic [31:0] frm_cnt_q [P_CHANNEL_NUM];
  logic [31:0] trunc_cnt_q, pad_cnt_q;
  logic        emit_last, data_acc;

  assign emit_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign data_acc  = (state_q == StData) & beat_acc;

  // Saturating frame, truncation and pad event counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < int'(P_CHANNEL_NUM); c++) begin
        frm_cnt_q[c] <= '0;
      end
      trunc_cnt_q <= '0;
      pad_cnt_q   <= '0;
    end else begin
      if (emit_last && (frm_cnt_q[grant_q] != '1)) begin
        frm_cnt_q[grant_q] <= frm_cnt_q[grant_q] + 32'd1;
      end
      if (data_acc && is_trunc && (trunc_cnt_q != '1)) begin
        trunc_cnt_q <= trunc_cnt_q + 32'd1;
      end
      if (data_acc && is_short && (pad_cnt_q != '1)) begin
        pad_cnt_q <= pad_cnt_q + 32'd1;
      end
    end
  end

  for (genvar c = 0; c < P_CHANNEL_NUM; c++) begin : g_frm_cnt
    assign o_frm_cnt[32*c +: 32] = frm_cnt_q[c];
  end
  assign o_trunc_cnt = trunc_cnt_q;
  assign o_pad_cnt   = pad_cnt_q;
`endif

endmodule

// File: tb/tb_eth_10g_mchnl_tx_arb.sv
// Self-checking bench for eth_10g_mchnl_tx_arb (default build, 4 channels, 64/9600 limits).
module tb_eth_10g_mchnl_tx_arb;

  localparam int NCH = 4;
  localparam int MINL = 64;
  localparam int MAXL = 9600;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    int         ch;
    int         len;
    bit         user;
    int         exp_beats;
    logic [7:0] exp_keep;
    bit         exp_user;
    int         exp_bytes;
  } vec_t;

  logic               i_clk, i_rst;
  logic [NCH-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic [64*NCH-1:0]  s_axis_tdata;
  logic [8*NCH-1:0]   s_axis_tkeep;
  logic               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [63:0]        m_axis_tdata;
  logic [7:0]         m_axis_tkeep;
  logic [1:0]         o_grant_chnl;
  logic               o_busy;

  eth_10g_mchnl_tx_arb #(
    .P_CHANNEL_NUM (NCH),
    .P_MIN_LENGTH  (8'd64),
    .P_MAX_LENGTH  (15'd9600)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .o_grant_chnl  (o_grant_chnl),
    .o_busy        (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    gap_en = 0;
  bit    rdy_rand = 0;
  beat_t src_q[NCH][$];
  beat_t exp_q[NCH][$];

  // Monitor state
  bit          in_frame = 0;
  int          cur_ch = 0;
  int          fr_beats, fr_bytes, fr_start;
  int          mon_frames = 0;
  int          last_beats, last_bytes, last_ch;
  logic [7:0]  last_keep;
  logic        last_user;
  int          ch_q[$];
  int          start_q[$];
  int          end_q[$];
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Build source beats and the expected emitted beats from byte-level frame rules.
  task automatic push_frame(input int ch, input int len, input bit user);
    logic [7:0] bytes[$];
    beat_t      b;
    int         out_len;
    bit         out_user;
    bytes.delete();
    bytes.push_back(8'hA0 | 8'(ch));
    for (int i = 1; i < len; i++) bytes.push_back(8'($urandom));
    for (int i = 0; i < len; i += 8) begin
      b = '0;
      for (int k = 0; k < 8; k++) begin
        if (i + k < len) begin
          b.data[8*k +: 8] = bytes[i+k];
          b.keep[k] = 1'b1;
        end
      end
      b.last = (i + 8 >= len);
      b.user = b.last & user;
      src_q[ch].push_back(b);
    end
    out_len  = (len > MAXL) ? MAXL : ((len < MINL) ? MINL : len);
    out_user = (len > MAXL) ? 1'b1 : user;
    for (int i = 0; i < out_len; i += 8) begin
      b = '0;
      for (int k = 0; k < 8; k++) begin
        if (i + k < out_len) begin
          b.keep[k] = 1'b1;
          if (i + k < len) b.data[8*k +: 8] = bytes[i+k];
        end
      end
      b.last = (i + 8 >= out_len);
      b.user = b.last & out_user;
      exp_q[ch].push_back(b);
    end
  endtask

  task automatic mon_beat();
    beat_t       e;
    logic [63:0] m;
    bit          ok;
    if (!in_frame) begin
      in_frame = 1;
      fr_beats = 0;
      fr_bytes = 0;
      fr_start = cyc;
      cur_ch   = int'(m_axis_tdata[3:0]);
      if (m_axis_tdata[7:4] != 4'hA || cur_ch >= NCH) begin
        errors++;
        checks++;
        $display("FAIL frame_tag: got %h, want A0..A3", m_axis_tdata[7:0]);
        cur_ch = -1;
      end
    end
    if (cur_ch >= 0) begin
      checks++;
      if (exp_q[cur_ch].size() == 0) begin
        errors++;
        $display("FAIL extra_beat ch%0d: got data=%h, want no beat", cur_ch, m_axis_tdata);
      end else begin
        e = exp_q[cur_ch].pop_front();
        m = '0;
        for (int k = 0; k < 8; k++) if (e.keep[k]) m[8*k +: 8] = 8'hFF;
        ok = ((m_axis_tdata & m) == e.data) && (m_axis_tkeep == e.keep) &&
             (m_axis_tlast == e.last) && (!e.last || (m_axis_tuser == e.user)) &&
             (o_grant_chnl == 2'(cur_ch));
        if (!ok) begin
          errors++;
          $display("FAIL beat ch%0d: got d=%h k=%h l=%b u=%b g=%0d, want d=%h k=%h l=%b u=%b",
                   cur_ch, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                   o_grant_chnl, e.data, e.keep, e.last, e.user);
        end
      end
    end
    fr_beats++;
    fr_bytes += $countones(m_axis_tkeep);
    if (m_axis_tlast) begin
      in_frame   = 0;
      mon_frames++;
      last_beats = fr_beats;
      last_bytes = fr_bytes;
      last_keep  = m_axis_tkeep;
      last_user  = m_axis_tuser;
      last_ch    = cur_ch;
      ch_q.push_back(cur_ch);
      start_q.push_back(fr_start);
      end_q.push_back(cyc);
    end
  endtask

  // Source drivers, MAC ready, output monitor and hold-stability check.
  initial begin : bfm
    logic [NCH-1:0] acc;
    beat_t          b;
    acc = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (i_rst) begin
        in_frame   = 0;
        prev_stall = 0;
        acc        = '0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tkeep == prev_keep &&
                m_axis_tlast == prev_last)) begin
            errors++;
            $display("FAIL hold: got v=%b d=%h k=%h l=%b, want v=1 d=%h k=%h l=%b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                     prev_data, prev_keep, prev_last);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_keep  = m_axis_tkeep;
        prev_last  = m_axis_tlast;
        acc = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) mon_beat();
      end
      @(posedge i_clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (acc[c] && src_q[c].size() > 0) b = src_q[c].pop_front();
        if (src_q[c].size() == 0) begin
          s_axis_tvalid[c] = 1'b0;
        end else if (!(s_axis_tvalid[c] && !acc[c])) begin
          s_axis_tvalid[c] = !gap_en || ($urandom_range(0, 7) != 0);
        end
        if (src_q[c].size() > 0) begin
          b = src_q[c][0];
          s_axis_tdata[64*c +: 64] = b.data;
          s_axis_tkeep[8*c +: 8]   = b.keep;
          s_axis_tlast[c]          = b.last;
          s_axis_tuser[c]          = b.user;
        end
      end
      m_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (mon_frames < target && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("frames_done", mon_frames, target);
  endtask

  function automatic bit all_idle();
    bit r = !o_busy;
    for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0 || exp_q[c].size() != 0) r = 0;
    return r;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("idle_reached", int'(all_idle()), 1);
  endtask

  vec_t vecs[11];
  int   rr_exp[6];
  int   t;

  initial begin : main
    vecs[0]  = '{ch: 0, len: 128,  user: 0, exp_beats: 16,   exp_keep: 8'hFF, exp_user: 0,
                 exp_bytes: 128};
    vecs[1]  = '{ch: 1, len: 20,   user: 1, exp_beats: 8,    exp_keep: 8'hFF, exp_user: 1,
                 exp_bytes: 64};
    vecs[2]  = '{ch: 2, len: 64,   user: 0, exp_beats: 8,    exp_keep: 8'hFF, exp_user: 0,
                 exp_bytes: 64};
    vecs[3]  = '{ch: 3, len: 60,   user: 0, exp_beats: 8,    exp_keep: 8'hFF, exp_user: 0,
                 exp_bytes: 64};
    vecs[4]  = '{ch: 0, len: 1,    user: 0, exp_beats: 8,    exp_keep: 8'hFF, exp_user: 0,
                 exp_bytes: 64};
    vecs[5]  = '{ch: 1, len: 65,   user: 0, exp_beats: 9,    exp_keep: 8'h01, exp_user: 0,
                 exp_bytes: 65};
    vecs[6]  = '{ch: 2, len: 9600, user: 0, exp_beats: 1200, exp_keep: 8'hFF, exp_user: 0,
                 exp_bytes: 9600};
    vecs[7]  = '{ch: 3, len: 9608, user: 0, exp_beats: 1200, exp_keep: 8'hFF, exp_user: 1,
                 exp_bytes: 9600};
    vecs[8]  = '{ch: 0, len: 9604, user: 0, exp_beats: 1200, exp_keep: 8'hFF, exp_user: 1,
                 exp_bytes: 9600};
    vecs[9]  = '{ch: 1, len: 9597, user: 1, exp_beats: 1200, exp_keep: 8'h1F, exp_user: 1,
                 exp_bytes: 9597};
    vecs[10] = '{ch: 2, len: 71,   user: 1, exp_beats: 9,    exp_keep: 8'h7F, exp_user: 1,
                 exp_bytes: 71};
    rr_exp = '{0, 1, 2, 0, 1, 2};

    i_rst         = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_m_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_s_tready", int'(s_axis_tready), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_grant", int'(o_grant_chnl), 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Round robin across three continuously requesting channels.
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) push_frame(c, 64, 0);
    wait_frames(6, 2000);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order[%0d]", i), ch_q[i], rr_exp[i]);
    wait_idle(200);

    // Back-to-back 128-byte frames: 16 beats each, one idle bubble between.
    start_q.delete();
    end_q.delete();
    t = mon_frames + 2;
    push_frame(0, 128, 0);
    push_frame(0, 128, 0);
    wait_frames(t, 1000);
    chk("b2b_beats", last_beats, 16);
    chk("b2b_len", end_q[0] - start_q[0], 15);
    chk("b2b_bubble", start_q[1] - end_q[0], 2);
    wait_idle(200);

    // Table of frame lengths under random source gaps and MAC backpressure.
    gap_en   = 1;
    rdy_rand = 1;
    for (int v = 0; v < 11; v++) begin
      t = mon_frames + 1;
      push_frame(vecs[v].ch, vecs[v].len, vecs[v].user);
      wait_frames(t, 6000);
      wait_idle(4000);
      chk($sformatf("v%0d_ch", v), last_ch, vecs[v].ch);
      chk($sformatf("v%0d_beats", v), last_beats, vecs[v].exp_beats);
      chk($sformatf("v%0d_keep", v), int'(last_keep), int'(vecs[v].exp_keep));
      chk($sformatf("v%0d_user", v), int'(last_user), int'(vecs[v].exp_user));
      chk($sformatf("v%0d_bytes", v), last_bytes, vecs[v].exp_bytes);
    end

    // Reset while padding, then a clean frame on channel 1.
    gap_en   = 0;
    rdy_rand = 0;
    push_frame(2, 20, 0);
    t = 0;
    while (src_q[2].size() != 0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    chk("pad_entered", int'(o_busy), 1);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    chk("rstpad_m_tvalid", int'(m_axis_tvalid), 0);
    chk("rstpad_m_tdata_keep", int'(|{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 0);
    chk("rstpad_s_tready", int'(s_axis_tready), 0);
    chk("rstpad_busy", int'(o_busy), 0);
    chk("rstpad_grant", int'(o_grant_chnl), 0);
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    t = mon_frames + 1;
    push_frame(1, 64, 0);
    wait_frames(t, 500);
    chk("post_rst_ch", last_ch, 1);
    chk("post_rst_beats", last_beats, 8);
    chk("post_rst_bytes", last_bytes, 64);
    wait_idle(200);

    // Random frames on all channels with random gaps and backpressure.
    gap_en   = 1;
    rdy_rand = 1;
    for (int k = 0; k < 40; k++) begin
      int ch, len;
      ch  = int'($urandom_range(0, NCH - 1));
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9590, 9615))
                                         : int'($urandom_range(1, 200));
      push_frame(ch, len, 1'($urandom_range(0, 1)));
    end
    wait_idle(60000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
